// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// One line bit per baud tick; TX_OUT, busy and done are registered alongside the state.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  done
);

  localparam int             BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]  ONE      = BW'(1);
  localparam bit             TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic w_stop_last;
  logic w_par_bit;

  // Any STOP_BITS other than 2 behaves as a single stop bit.
  assign w_stop_last = TWO_STOP ? r_stop_cnt : 1'b1;
  assign w_par_bit   = (^r_data) ^ r_par_typ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (Data_valid) begin
            r_shreg   <= P_DATA;
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_busy    <= 1'b1;
            r_state   <= S_ARM;
          end
        end
        S_ARM: begin
          if (tick) begin
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            r_bit_cnt <= '0;
            r_tx      <= r_shreg[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            r_shreg   <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + ONE;
            if (r_bit_cnt == LAST_BIT) begin
              r_stop_cnt <= 1'b0;
              if (r_par_en) begin
                r_tx    <= w_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_tx <= r_shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (w_stop_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl: one-stop (u1) and two-stop (u2) instances, tick every 4 cycles.
// Expected line sequences are hand-written strings, first character = start bit.
module tb_uart_tx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic       tick;
  logic [7:0] P_DATA;
  logic       v1;
  logic       v2;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;

  int total = 0;
  int bad   = 0;
  int phase = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u1 (
    .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA), .Data_valid(v1),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx1), .busy(busy1), .done(done1)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u2 (
    .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA), .Data_valid(v2),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx2), .busy(busy2), .done(done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Outputs are read at the negedge; inputs set here apply at the following posedge.
  task automatic nxt();
    @(negedge CLK);
    tick  = (phase == 3);
    phase = (phase + 1) % 4;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic o_tx(input bit sel);
    return sel ? tx2 : tx1;
  endfunction

  function automatic logic o_busy(input bit sel);
    return sel ? busy2 : busy1;
  endfunction

  function automatic logic o_done(input bit sel);
    return sel ? done2 : done1;
  endfunction

  task automatic set_valid(input bit sel, input logic val);
    if (sel) v2 = val;
    else     v1 = val;
  endtask

  task automatic do_accept(input string tag, input bit sel, input logic [7:0] d,
                           input logic pe, input logic pt);
    P_DATA  = d;
    PAR_EN  = pe;
    PAR_TYP = pt;
    set_valid(sel, 1'b1);
    nxt();
    set_valid(sel, 1'b0);
    chk({tag, "_arm_busy"}, o_busy(sel), 1'b1);
    chk({tag, "_arm_tx"},   o_tx(sel),   1'b1);
    chk({tag, "_arm_done"}, o_done(sel), 1'b0);
  endtask

  task automatic wait_start(input string tag, input bit sel);
    int k = 0;
    while (o_tx(sel) !== 1'b0 && k < 10) begin
      nxt();
      k++;
    end
    chk({tag, "_start_seen"}, o_tx(sel), 1'b0);
  endtask

  // Checks every cycle of the frame, each bit held for 4 cycles, then the done cycle.
  // inj >= 0 raises a dropped request with different inputs during that line bit.
  task automatic run_frame(input string tag, input bit sel, input string bits, input int inj);
    logic e;
    wait_start(tag, sel);
    for (int i = 0; i < bits.len(); i++) begin
      e = (bits[i] == "1");
      for (int c = 0; c < 4; c++) begin
        if (!(i == 0 && c == 0)) nxt();
        chk($sformatf("%s_bit%0d_c%0d_tx", tag, i, c), o_tx(sel), e);
        chk($sformatf("%s_bit%0d_c%0d_busy", tag, i, c), o_busy(sel), 1'b1);
        chk($sformatf("%s_bit%0d_c%0d_done", tag, i, c), o_done(sel), 1'b0);
        if (i == inj && c == 1) begin
          P_DATA  = 8'h3C;
          PAR_EN  = ~PAR_EN;
          PAR_TYP = ~PAR_TYP;
          set_valid(sel, 1'b1);
        end
        if (i == inj && c == 2) set_valid(sel, 1'b0);
      end
    end
    nxt();
    chk({tag, "_done_pulse"}, o_done(sel), 1'b1);
    chk({tag, "_done_busy"},  o_busy(sel), 1'b0);
    chk({tag, "_done_tx"},    o_tx(sel),   1'b1);
  endtask

  task automatic after_frame(input string tag, input bit sel);
    nxt();
    chk({tag, "_post_done"}, o_done(sel), 1'b0);
    chk({tag, "_post_busy"}, o_busy(sel), 1'b0);
    chk({tag, "_post_tx"},   o_tx(sel),   1'b1);
  endtask

  initial begin
    RST = 1'b1; tick = 1'b0; P_DATA = 8'h00; v1 = 1'b0; v2 = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // Reset held 2 cycles with random inputs.
    for (int r = 0; r < 2; r++) begin
      P_DATA  = 8'($urandom);
      v1      = 1'($urandom);
      v2      = 1'($urandom);
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
      nxt();
      chk($sformatf("rst%0d_tx1", r), tx1, 1'b1);
      chk($sformatf("rst%0d_busy1", r), busy1, 1'b0);
      chk($sformatf("rst%0d_done1", r), done1, 1'b0);
      chk($sformatf("rst%0d_tx2", r), tx2, 1'b1);
      chk($sformatf("rst%0d_busy2", r), busy2, 1'b0);
      chk($sformatf("rst%0d_done2", r), done2, 1'b0);
    end
    RST = 1'b0; v1 = 1'b0; v2 = 1'b0;
    nxt();
    nxt();
    chk("idle_tx1", tx1, 1'b1);
    chk("idle_busy1", busy1, 1'b0);

    // 0xA5, no parity.
    do_accept("a5", 1'b0, 8'hA5, 1'b0, 1'b0);
    run_frame("a5", 1'b0, "0101001011", -1);
    after_frame("a5", 1'b0);
    nxt();

    // 0x01 even parity -> parity 1; odd parity -> parity 0.
    do_accept("p_even", 1'b0, 8'h01, 1'b1, 1'b0);
    run_frame("p_even", 1'b0, "01000000011", -1);
    after_frame("p_even", 1'b0);
    do_accept("p_odd", 1'b0, 8'h01, 1'b1, 1'b1);
    run_frame("p_odd", 1'b0, "01000000001", -1);
    after_frame("p_odd", 1'b0);
    nxt();

    // Two stop bits on u2: 0xFF, no parity.
    do_accept("stop2", 1'b1, 8'hFF, 1'b0, 1'b0);
    run_frame("stop2", 1'b1, "01111111111", -1);
    after_frame("stop2", 1'b1);
    nxt();

    // 0xC3 odd parity with a dropped mid-frame request; then a request on the done cycle.
    do_accept("drop", 1'b0, 8'hC3, 1'b1, 1'b1);
    run_frame("drop", 1'b0, "01100001111", 3);
    do_accept("chain", 1'b0, 8'h3C, 1'b0, 1'b0);
    run_frame("chain", 1'b0, "0001111001", -1);
    after_frame("chain", 1'b0);
    nxt();

    // Reset during data bit 3 (line bit 4, cycle 1).
    do_accept("abort", 1'b0, 8'hA5, 1'b0, 1'b0);
    wait_start("abort", 1'b0);
    for (int c = 0; c < 17; c++) nxt();
    chk("abort_pre_tx", tx1, 1'b0);
    chk("abort_pre_busy", busy1, 1'b1);
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    chk("abort_tx", tx1, 1'b1);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_done", done1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      nxt();
      chk($sformatf("abort_hold%0d_tx", c), tx1, 1'b1);
      chk($sformatf("abort_hold%0d_busy", c), busy1, 1'b0);
    end
    do_accept("x5a", 1'b0, 8'h5A, 1'b0, 1'b0);
    run_frame("x5a", 1'b0, "0010110101", -1);
    after_frame("x5a", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
